// File: rtl/ssp_tx_fifo.sv
// Transmit byte queue feeding the SSP serial shifter.
// Bus writes push bytes; the shifter's TX_POP pulse retires the head byte.
module ssp_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             PCLK,
    input  logic             CLEAR,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] PWDATA,
    input  logic             TX_POP,
    output logic [WIDTH-1:0] TXDATA,
    output logic             TX_VALID,
    output logic             SSPTXINTR,
    output logic [AW:0]      LEVEL,
    output logic             OVERRUN
);

    localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             overrun_q, overrun_d;

    logic full, empty;
    logic push_req, pop_req, push_ok, pop_ok;

    assign full     = (cnt_q == CntFull);
    assign empty    = (cnt_q == '0);
    assign push_req = PSEL & PWRITE;
    assign pop_req  = TX_POP;
    assign pop_ok   = pop_req & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop_ok);

    always_comb begin
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wp_d = wp_q + PtrOne;
        end
        if (pop_ok) begin
            rp_d = rp_q + PtrOne;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
        if (push_req && !push_ok) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset; empty masks stale contents on TXDATA.
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_q[wp_q] <= PWDATA;
        end
    end

    assign TXDATA    = empty ? '0 : mem_q[rp_q];
    assign TX_VALID  = ~empty;
    assign SSPTXINTR = full;
    assign LEVEL     = cnt_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed self-checking bench for ssp_tx_fifo.
module tb_ssp_tx_fifo;

    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic       PSEL = 1'b0;
    logic       PWRITE = 1'b0;
    logic [7:0] PWDATA = 8'h00;
    logic       TX_POP = 1'b0;
    logic [7:0] TXDATA;
    logic       TX_VALID;
    logic       SSPTXINTR;
    logic [2:0] LEVEL;
    logic       OVERRUN;

    int total = 0;
    int bad = 0;

    ssp_tx_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .TX_POP    (TX_POP),
        .TXDATA    (TXDATA),
        .TX_VALID  (TX_VALID),
        .SSPTXINTR (SSPTXINTR),
        .LEVEL     (LEVEL),
        .OVERRUN   (OVERRUN)
    );

    always #5 PCLK = ~PCLK;

    // Advance past one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        CLEAR = 1'b1;
        #1;
        total++;
        if ({TX_VALID, SSPTXINTR, LEVEL, TXDATA, OVERRUN} !== {1'b0, 1'b0, 3'd0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: got valid=%b intr=%b level=%0d data=%h ovr=%b want 0 0 0 00 0",
                     TX_VALID, SSPTXINTR, LEVEL, TXDATA, OVERRUN);
        end
        cycle();
        CLEAR = 1'b0;
        cycle();
        total++;
        if ({TX_VALID, LEVEL} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_idle: got valid=%b level=%0d want 0 0", TX_VALID, LEVEL);
        end
    endtask

    task automatic test_single();
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'hA5;
        #1;
        total++;
        if (TXDATA !== 8'h00) begin
            bad++;
            $display("FAIL no_bypass: got %h want 00", TXDATA);
        end
        cycle();
        PSEL = 1'b0; PWRITE = 1'b0;
        total++;
        if ({TXDATA, TX_VALID, LEVEL} !== {8'hA5, 1'b1, 3'd1}) begin
            bad++;
            $display("FAIL single_push: got data=%h valid=%b level=%0d want a5 1 1",
                     TXDATA, TX_VALID, LEVEL);
        end
        TX_POP = 1'b1;
        cycle();
        TX_POP = 1'b0;
        total++;
        if ({TXDATA, TX_VALID, LEVEL} !== {8'h00, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL single_pop: got data=%h valid=%b level=%0d want 00 0 0",
                     TXDATA, TX_VALID, LEVEL);
        end
    endtask

    task automatic fill4();
        PSEL = 1'b1; PWRITE = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            PWDATA = 8'(i * 8'h11);
            cycle();
        end
        PSEL = 1'b0; PWRITE = 1'b0;
    endtask

    // Holds TX_POP high and expects the given head bytes in order, then empty.
    task automatic drain4(input logic [31:0] seq, input string name);
        logic [7:0] exp;
        TX_POP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = seq[31-8*i -: 8];
            total++;
            if (TXDATA !== exp) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", name, i, TXDATA, exp);
            end
            cycle();
        end
        TX_POP = 1'b0;
        total++;
        if ({TX_VALID, LEVEL} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL %s_empty: got valid=%b level=%0d want 0 0", name, TX_VALID, LEVEL);
        end
    endtask

    task automatic test_fill_order();
        fill4();
        total++;
        if ({SSPTXINTR, LEVEL, OVERRUN} !== {1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL fill_full: got intr=%b level=%0d ovr=%b want 1 4 0",
                     SSPTXINTR, LEVEL, OVERRUN);
        end
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'h55;
        cycle();
        PSEL = 1'b0; PWRITE = 1'b0;
        total++;
        if ({OVERRUN, LEVEL, TXDATA} !== {1'b1, 3'd4, 8'h11}) begin
            bad++;
            $display("FAIL overrun: got ovr=%b level=%0d head=%h want 1 4 11",
                     OVERRUN, LEVEL, TXDATA);
        end
        drain4(32'h11223344, "fill_drain");
    endtask

    task automatic test_full_push_pop();
        fill4();
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'h66; TX_POP = 1'b1;
        cycle();
        PSEL = 1'b0; PWRITE = 1'b0; TX_POP = 1'b0;
        total++;
        if ({LEVEL, SSPTXINTR, OVERRUN} !== {3'd4, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL full_pushpop: got level=%0d intr=%b ovr=%b want 4 1 1",
                     LEVEL, SSPTXINTR, OVERRUN);
        end
        drain4(32'h22334466, "full_drain");
    endtask

    task automatic test_empty_edges();
        TX_POP = 1'b1;
        cycle();
        total++;
        if ({LEVEL, TX_VALID} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL pop_empty: got level=%0d valid=%b want 0 0", LEVEL, TX_VALID);
        end
        // TX_POP still high: push into empty must win, pop ignored.
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'h9C;
        cycle();
        PSEL = 1'b0; PWRITE = 1'b0; TX_POP = 1'b0;
        total++;
        if ({LEVEL, TXDATA} !== {3'd1, 8'h9C}) begin
            bad++;
            $display("FAIL empty_pushpop: got level=%0d data=%h want 1 9c", LEVEL, TXDATA);
        end
        TX_POP = 1'b1;
        cycle();
        TX_POP = 1'b0;
    endtask

    task automatic test_wrap();
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'h00;
        cycle();
        TX_POP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                PSEL = 1'b0; PWRITE = 1'b0;
            end else begin
                PWDATA = 8'(i + 1);
            end
            total++;
            if ({TXDATA, LEVEL} !== {8'(i), 3'd1}) begin
                bad++;
                $display("FAIL wrap[%0d]: got data=%h level=%0d want %h 1", i, TXDATA, LEVEL, 8'(i));
            end
            cycle();
        end
        TX_POP = 1'b0;
        total++;
        if ({TX_VALID, LEVEL} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL wrap_empty: got valid=%b level=%0d want 0 0", TX_VALID, LEVEL);
        end
    endtask

    task automatic test_reset_mid();
        PSEL = 1'b1; PWRITE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PWDATA = 8'hA1 + 8'(i);
            cycle();
        end
        PSEL = 1'b0; PWRITE = 1'b0;
        total++;
        if ({LEVEL, OVERRUN} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset: got level=%0d ovr=%b want 3 1", LEVEL, OVERRUN);
        end
        #2;
        CLEAR = 1'b1;
        #1;
        total++;
        if ({LEVEL, OVERRUN, TX_VALID, TXDATA} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid: got level=%0d ovr=%b valid=%b data=%h want 0 0 0 00",
                     LEVEL, OVERRUN, TX_VALID, TXDATA);
        end
        cycle();
        CLEAR = 1'b0;
        PSEL = 1'b1; PWRITE = 1'b1; PWDATA = 8'h7E;
        cycle();
        PSEL = 1'b0; PWRITE = 1'b0;
        total++;
        if ({TXDATA, LEVEL, TX_VALID} !== {8'h7E, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL post_reset_push: got data=%h level=%0d valid=%b want 7e 1 1",
                     TXDATA, LEVEL, TX_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_order();
        test_full_push_pop();
        test_empty_edges();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the SSP serial shifter.
- Accepts bytes from the bus write interface (PSEL/PWRITE/PWDATA) and stores them in order.
- Presents the oldest byte on TXDATA with a valid flag, and retires it when the serial stage pulses TX_POP after loading it.
- Raises SSPTXINTR when full so software stops writing. Single clock domain: PCLK also drives the shifter's SSPCLK_IN.

Parameters:
WIDTH, 8, data width in bits (matches the shifter's TXDATA).
DEPTH, 4, number of entries; must be a power of two, at least 2.
AW, 2, pointer width, log2(DEPTH).

Ports:
PCLK  input  1  clock; all state updates on the rising edge.
CLEAR  input  1  asynchronous active-high reset.
PSEL  input  1  bus select for this FIFO.
PWRITE  input  1  write strobe; a push is requested when PSEL&PWRITE=1.
PWDATA  input  WIDTH  byte to push.
TX_POP  input  1  one-cycle pulse from the serial stage: head byte consumed.
TXDATA  output  WIDTH  head-of-queue byte to the serial stage.
TX_VALID  output  1  1 when the FIFO holds at least one byte.
SSPTXINTR  output  1  1 when the FIFO is full (count==DEPTH).
LEVEL  output  AW+1  current occupancy, 0..DEPTH.
OVERRUN  output  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Storage: DEPTH x WIDTH register array, write pointer wp[AW-1:0], read pointer rp[AW-1:0], counter cnt[AW:0]. Pointers wrap modulo DEPTH with natural overflow.
- Reset (CLEAR=1, asynchronous, any time including mid-operation):
  - wp=rp=0, cnt=0, OVERRUN=0.
  - TX_VALID=0, SSPTXINTR=0, LEVEL=0, TXDATA=0.
  - Array contents are don't-care.
  - Effect is immediate on assertion, not on the next edge.
- Derived flags, all computed from registered state:
  - full = (cnt==DEPTH); empty = (cnt==0).
  - TX_VALID = !empty; SSPTXINTR = full; LEVEL = cnt.
- TXDATA = mem[rp] when !empty, else all zeros. It is combinational from registered state and changes only after a clock edge.
- push_req = PSEL & PWRITE; pop_req = TX_POP.
- pop_ok = pop_req & !empty.
- push_ok = push_req & (!full | pop_ok). When full, a simultaneous push and pop both succeed and cnt stays at DEPTH.
- On a rising edge:
  - push_ok: mem[wp] <= PWDATA; wp <= wp+1.
  - pop_ok: rp <= rp+1.
  - cnt <= cnt + push_ok - pop_ok.
- Latency: a byte pushed into an empty FIFO appears on TXDATA, with TX_VALID=1, in the cycle after the push edge. Push-to-valid is 1 cycle.
- Empty with push+pop in the same cycle: the pop is ignored and the push is accepted. cnt becomes 1.
- Pop while empty: ignored, with no pointer movement. This is not an error.
- Push while full without a pop: data is dropped, state is unchanged, and OVERRUN <= 1. OVERRUN stays set until CLEAR.
- TX_POP held high for several cycles pops once per cycle until empty. The serial stage must pulse it exactly once per byte.
- Ordering is strict FIFO. No bypass path: a byte is never visible on TXDATA in the same cycle it is written.

Test Plan:
1. Reset then idle: assert CLEAR mid-cycle -> TX_VALID=0, SSPTXINTR=0, LEVEL=0, TXDATA=8'h00, OVERRUN=0 immediately, without waiting for a PCLK edge.
2. Single byte: push 8'hA5 -> next cycle TXDATA=8'hA5, TX_VALID=1, LEVEL=1. Pulse TX_POP -> next cycle TX_VALID=0, TXDATA=8'h00, LEVEL=0.
3. Fill and order: push 8'h11, 8'h22, 8'h33, 8'h44 -> SSPTXINTR=1, LEVEL=4. Push 8'h55 -> dropped, OVERRUN=1. Four pops -> TXDATA sequence 11, 22, 33, 44, then TX_VALID=0.
4. Full with simultaneous push+pop: FIFO holds 11, 22, 33, 44; push 8'h66 with TX_POP -> LEVEL stays 4, SSPTXINTR=1, OVERRUN unchanged. Drain order is 22, 33, 44, 66.
5. Wrap-around: run 10 interleaved push/pop pairs with incrementing data 8'h00..8'h09 at LEVEL 1-2 -> output matches input order across pointer wrap, and LEVEL never exceeds 2.
6. Reset mid-operation: with LEVEL=3, assert CLEAR for one cycle -> LEVEL=0 and OVERRUN=0. A subsequent push of 8'h7E appears as the head, not stale data.
